// File: rtl/operand_fetch_pkg.sv
// Purpose: shared types and constants for the operand fetch stage.
//   N      operand data width
//   WORDS  number of architectural registers tracked by the scoreboard
//   M      register address width
//   opf_state_e   fetch FSM state encoding
//   id_instr_t    decode-side instruction payload
//   ex_payload_t  execute-side operand payload
package operand_fetch_pkg;

  localparam int unsigned N     = 32;
  localparam int unsigned WORDS = 32;
  localparam int unsigned M     = 5;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    READ = 2'b01,
    HOLD = 2'b10
  } opf_state_e;

  typedef struct packed {
    logic [M-1:0] rs1;
    logic [M-1:0] rs2;
    logic [M-1:0] rd;
    logic         use1;
    logic         use2;
    logic         wrd;
  } id_instr_t;

  typedef struct packed {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [M-1:0] rd;
    logic         wrd;
  } ex_payload_t;

  // Operand source priority: r0 / unused source, then writeback bypass, then RF.
  function automatic logic [N-1:0] select_operand(
    input logic [M-1:0] rs,
    input logic         use_src,
    input logic         bypass,
    input logic [N-1:0] wb_data,
    input logic [N-1:0] rf_out
  );
    logic [N-1:0] op;
    if ((rs == '0) || !use_src) begin
      op = '0;
    end else if (bypass) begin
      op = wb_data;
    end else begin
      op = rf_out;
    end
    return op;
  endfunction

endpackage

// File: rtl/operand_fetch_if.sv
// Purpose: decode-side and execute-side handshakes of the operand fetch stage.
//   id_valid/id_ready/id_instr  instruction from decode
//   ex_valid/ex_ready/ex_data   operands towards execute
// Modports: slave = operand fetch stage, master = surrounding pipeline.
interface operand_fetch_if;
  import operand_fetch_pkg::*;

  logic        id_valid;
  logic        id_ready;
  id_instr_t   id_instr;

  logic        ex_valid;
  logic        ex_ready;
  ex_payload_t ex_data;

  modport slave (
    input  id_valid,
    input  id_instr,
    output id_ready,
    output ex_valid,
    output ex_data,
    input  ex_ready
  );

  modport master (
    output id_valid,
    output id_instr,
    input  id_ready,
    input  ex_valid,
    input  ex_data,
    output ex_ready
  );

endinterface

// File: rtl/opf_scoreboard.sv
// Purpose: pending-write scoreboard and per-source hazard detection.
//   clk, rst            clock, asynchronous active-high reset
//   set_en, set_addr    mark a destination pending (execute handshake)
//   clr_en, clr_addr    writeback; clears pending and acts as a bypass
//   rs1/use1, rs2/use2  sources of the instruction being fetched
//   hazard1, hazard2    source must wait (combinational)
module opf_scoreboard
  import operand_fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         set_en,
  input  logic [M-1:0] set_addr,
  input  logic         clr_en,
  input  logic [M-1:0] clr_addr,
  input  logic [M-1:0] rs1,
  input  logic         use1,
  input  logic [M-1:0] rs2,
  input  logic         use2,
  output logic         hazard1,
  output logic         hazard2
);

  logic [WORDS-1:0] pending;
  logic [WORDS-1:0] pending_nxt;

  // Clear first so a same-cycle set of the same bit wins; r0 is never pending.
  always_comb begin
    pending_nxt = pending;
    if (clr_en) begin
      pending_nxt[clr_addr] = 1'b0;
    end
    if (set_en) begin
      pending_nxt[set_addr] = 1'b1;
    end
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
    end else begin
      pending <= pending_nxt;
    end
  end

  // A writeback landing on the source this cycle resolves the hazard via bypass.
  assign hazard1 = use1 && (rs1 != '0) && pending[rs1] && !(clr_en && (clr_addr == rs1));
  assign hazard2 = use2 && (rs2 != '0) && pending[rs2] && !(clr_en && (clr_addr == rs2));

endmodule

// File: rtl/operand_fetch.sv
// Purpose: operand fetch stage. Accepts one instruction at a time from decode,
// reads its sources from the register file (waiting on scoreboard hazards,
// bypassing same-cycle writeback data) and presents the operands to execute.
//   clk, rst              clock, asynchronous active-high reset
//   bus                   decode / execute handshakes (slave modport)
//   flush                 drop the instruction currently held
//   wb_we/wb_addr/wb_data writeback port (also the RF write port)
//   rf_r1/rf_r2           RF read addresses (registered captured sources)
//   rf_re1/rf_re2         RF read enables (combinational, depend on hazards)
//   rf_out1/rf_out2       RF read data
module operand_fetch
  import operand_fetch_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  operand_fetch_if.slave  bus,
  input  logic            flush,
  input  logic            wb_we,
  input  logic [M-1:0]    wb_addr,
  input  logic [N-1:0]    wb_data,
  output logic [M-1:0]    rf_r1,
  output logic [M-1:0]    rf_r2,
  output logic            rf_re1,
  output logic            rf_re2,
  input  logic [N-1:0]    rf_out1,
  input  logic [N-1:0]    rf_out2
);

  opf_state_e  state;
  id_instr_t   instr;
  ex_payload_t ex_q;
  logic        ex_valid_q;

  logic        haz1;
  logic        haz2;
  logic        byp1;
  logic        byp2;
  logic        sb_set;

  assign byp1 = wb_we && (wb_addr == instr.rs1);
  assign byp2 = wb_we && (wb_addr == instr.rs2);

  // Destination becomes pending when execute takes it, unless flushed away.
  assign sb_set = ex_valid_q && bus.ex_ready && !flush && ex_q.wrd && (ex_q.rd != '0);

  opf_scoreboard u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .set_en   (sb_set),
    .set_addr (ex_q.rd),
    .clr_en   (wb_we),
    .clr_addr (wb_addr),
    .rs1      (instr.rs1),
    .use1     (instr.use1),
    .rs2      (instr.rs2),
    .use2     (instr.use2),
    .hazard1  (haz1),
    .hazard2  (haz2)
  );

  // Decode ready is held low for as long as reset is asserted.
  assign bus.id_ready = (state == IDLE) && !rst;
  assign bus.ex_valid = ex_valid_q;
  assign bus.ex_data  = ex_q;

  assign rf_r1  = instr.rs1;
  assign rf_r2  = instr.rs2;
  assign rf_re1 = (state == READ) && instr.use1 && !haz1;
  assign rf_re2 = (state == READ) && instr.use2 && !haz2;

  // Fetch FSM; flush overrides every state and any same-cycle EX handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      instr      <= '0;
      ex_q       <= '0;
      ex_valid_q <= 1'b0;
    end else if (flush) begin
      state      <= IDLE;
      ex_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.id_valid) begin
            instr <= bus.id_instr;
            state <= READ;
          end
        end
        READ: begin
          if (!haz1 && !haz2) begin
            ex_q.a     <= select_operand(instr.rs1, instr.use1, byp1, wb_data, rf_out1);
            ex_q.b     <= select_operand(instr.rs2, instr.use2, byp2, wb_data, rf_out2);
            ex_q.rd    <= instr.rd;
            ex_q.wrd   <= instr.wrd;
            ex_valid_q <= 1'b1;
            state      <= HOLD;
          end
        end
        HOLD: begin
          if (bus.ex_ready) begin
            ex_valid_q <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          state      <= IDLE;
          ex_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
